// File: rtl/axi_rd_stream_master.sv
// AXI4 burst reader that streams fetched words out of an AXI-Stream port.
// A credit-managed skid FIFO decouples R beats from downstream backpressure.
module axi_rd_stream_master #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] addr_base,
  input  logic [ADDR_WIDTH-1:0] addr_offset,
  input  logic [31:0]           xfer_bytes,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  input  logic [1:0]            m_axi_rresp,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] start;
  logic [31:0]           total_beats;
  logic [31:0]           ar_issued;
  logic [31:0]           outstanding;
  logic [31:0]           out_beats;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;

  logic [31:0] req_beats;
  logic [31:0] ar_rem;
  logic [31:0] n;
  logic [31:0] credit;
  logic [31:0] ar_beats;
  logic        accept;
  logic        ar_hs;
  logic        r_hs;
  logic        pop;
  logic        rlast_unused;

  // Beats are counted, so rlast carries no information here.
  assign rlast_unused = m_axi_rlast;

  assign req_beats = (xfer_bytes >> BSH)
                   + 32'(|xfer_bytes[BSH-1:0]);
  assign ar_rem    = total_beats - ar_issued;
  assign n         = (ar_rem < 32'(BURST_LEN))
                   ? ar_rem : 32'(BURST_LEN);
  assign credit    = 32'(FIFO_DEPTH) - 32'(count)
                   - outstanding;
  assign ar_beats  = 32'(m_axi_arlen) + 32'd1;

  assign accept = req & ((state == IDLE) | (state == FINISH));
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid & m_axi_rready;
  assign pop    = m_axis_tvalid & m_axis_tready;

  assign m_axi_rready  = busy;
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (r_hs) mem[wptr] <= m_axi_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (r_hs) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({r_hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      start         <= '0;
      total_beats   <= '0;
      ar_issued     <= '0;
      outstanding   <= '0;
      out_beats     <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else begin
      outstanding <= outstanding
                   + (ar_hs ? ar_beats : 32'd0)
                   - {31'd0, r_hs};
      if (pop) out_beats <= out_beats + 32'd1;
      if (r_hs && m_axi_rresp != 2'b00) err <= 1'b1;
      unique case (state)
        IDLE: begin
        end
        ISSUE: begin
          if (m_axi_arvalid) begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              ar_issued     <= ar_issued + ar_beats;
              if (ar_beats == ar_rem) state <= WAIT;
            end
          end else if (credit >= n) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= start
                           + (ADDR_WIDTH'(ar_issued) << BSH);
            m_axi_arlen   <= 8'(n - 32'd1);
          end
        end
        WAIT: begin
          // Raise done together with the final stream handshake.
          if (pop && out_beats + 32'd1 == total_beats) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        start       <= addr_base + addr_offset;
        total_beats <= req_beats;
        ar_issued   <= '0;
        out_beats   <= '0;
        err         <= 1'b0;
        if (req_beats == 32'd0) begin
          state <= FINISH;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state <= ISSUE;
          done  <= 1'b0;
          busy  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_stream_master.sv
// Directed bench: AXI read slave model plus stream sink with per-beat checks.
// Expected addresses, lengths, data and timing are derived from request args.
module tb_axi_rd_stream_master;
  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] addr_base = '0;
  logic [AW-1:0] addr_offset = '0;
  logic [31:0]   xfer_bytes = '0;
  logic          done;
  logic          busy;
  logic          err;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b1;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata = '0;
  logic          m_axi_rlast = 1'b0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [DW-1:0] m_axis_tdata;

  axi_rd_stream_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .addr_base     (addr_base),
    .addr_offset   (addr_offset),
    .xfer_bytes    (xfer_bytes),
    .done          (done),
    .busy          (busy),
    .err           (err),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rresp   (m_axi_rresp),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [63:0] rq[$];
  bit          rlq[$];
  logic [63:0] ar_addr_q[$];
  int          ar_len_q[$];
  logic [63:0] exp_start;
  int total, r_cnt, t_cnt, ar_beats, done_cnt;
  int done_cyc, last_t_cyc, err_cyc, bad_cyc, req_cyc;
  int err_beat, arv_cycles, max_buf, stab_bad;
  bit ar_stall = 1'b0;
  bit p_arpend, p_tpend;
  logic [63:0] p_addr;
  logic [7:0]  p_len;
  logic [DW-1:0] p_data;

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    logic [DW-1:0] r;
    logic [63:0]   k;
    for (int j = 0; j < 8; j++) begin
      k = 64'h0123_4567_89ab_cdef * 64'(j + 1);
      r[j*64 +: 64] = a ^ k;
    end
    return r;
  endfunction

  // Slave drives at negedge, then records the handshakes of the next edge.
  initial begin : slave
    int n;
    int exp_len;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        rlq.delete();
        m_axi_rvalid = 1'b0;
      end else if (rq.size() != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pat(rq[0]);
        m_axi_rlast  = rlq[0];
        m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
      end
      m_axi_arready = ar_stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (!rst_n) begin
        p_arpend = 1'b0;
        p_tpend  = 1'b0;
      end else begin
        if (m_axi_arvalid) arv_cycles++;
        if (p_arpend && (!m_axi_arvalid || m_axi_araddr != p_addr
            || m_axi_arlen != p_len)) stab_bad++;
        if (p_tpend && (!m_axis_tvalid || m_axis_tdata != p_data))
          stab_bad++;
        p_arpend = m_axi_arvalid & ~m_axi_arready;
        p_addr   = m_axi_araddr;
        p_len    = m_axi_arlen;
        p_tpend  = m_axis_tvalid & ~m_axis_tready;
        p_data   = m_axis_tdata;
        if (m_axi_arvalid && m_axi_arready) begin
          n = int'(m_axi_arlen) + 1;
          exp_len = ((total - ar_beats) < 16) ? (total - ar_beats) : 16;
          chk("credit", (32 - (r_cnt - t_cnt) - (ar_beats - r_cnt)) >= n, 1);
          chk("araddr", m_axi_araddr, exp_start + 64'(ar_beats) * 64);
          chk("arlen", m_axi_arlen, exp_len - 1);
          ar_addr_q.push_back(m_axi_araddr);
          ar_len_q.push_back(int'(m_axi_arlen));
          for (int i = 0; i < n; i++) begin
            rq.push_back(m_axi_araddr + 64'(i) * 64);
            rlq.push_back(i == n - 1);
          end
          ar_beats += n;
        end
        if (m_axi_rvalid && m_axi_rready) begin
          if (m_axi_rresp != 2'b00) bad_cyc = cyc;
          void'(rq.pop_front());
          void'(rlq.pop_front());
          r_cnt++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          chk("tdata", m_axis_tdata, pat(exp_start + 64'(t_cnt) * 64));
          last_t_cyc = cyc;
          t_cnt++;
        end
        if (r_cnt - t_cnt > max_buf) max_buf = r_cnt - t_cnt;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (err && err_cyc < 0) err_cyc = cyc;
      end
    end
  end

  task automatic start_xfer(input logic [63:0] base,
                            input logic [63:0] off,
                            input int bytes,
                            input int eb);
    @(negedge clk);
    exp_start = base + off;
    total = (bytes + 63) / 64;
    r_cnt = 0; t_cnt = 0; ar_beats = 0; done_cnt = 0;
    done_cyc = -1; last_t_cyc = -1; err_cyc = -1; bad_cyc = -1;
    err_beat = eb; arv_cycles = 0; max_buf = 0; stab_bad = 0;
    ar_addr_q.delete();
    ar_len_q.delete();
    addr_base = base;
    addr_offset = off;
    xfer_bytes = 32'(bytes);
    req = 1'b1;
    req_cyc = cyc;
    @(negedge clk);
    req = 1'b0;
    chk("busy_on", busy, total > 0);
    chk("err_clr", err, 0);
  endtask

  task automatic finish_xfer(input int beats);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("done_cnt", done_cnt, 1);
    chk("beats", t_cnt, beats);
    if (beats > 0) chk("done_lat", done_cyc - last_t_cyc, 1);
    else chk("done_lat", done_cyc - req_cyc, 1);
    chk("stable", stab_bad, 0);
    chk("busy_off", busy, 0);
  endtask

  initial begin : main
    int n;
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    rst_n = 1'b1;

    start_xfer(64'h1000, 64'h400, 2048, -1);
    finish_xfer(32);
    chk("t1_ar_cnt", ar_addr_q.size(), 2);
    chk("t1_ar0", ar_addr_q[0], 64'h1400);
    chk("t1_ar1", ar_addr_q[1], 64'h1800);
    chk("t1_len0", ar_len_q[0], 15);
    chk("t1_len1", ar_len_q[1], 15);

    start_xfer(64'h2000, 64'h0, 100, -1);
    finish_xfer(2);
    chk("t2_ar_cnt", ar_addr_q.size(), 1);
    chk("t2_len", ar_len_q[0], 1);

    m_axis_tready = 1'b0;
    start_xfer(64'h4000, 64'h0, 4096, -1);
    repeat (200) @(negedge clk);
    chk("t3_held", t_cnt, 0);
    m_axis_tready = 1'b1;
    finish_xfer(64);
    chk("t3_max_buf", max_buf, 32);
    chk("t3_ar_cnt", ar_addr_q.size(), 4);

    start_xfer(64'h5000, 64'h0, 0, -1);
    finish_xfer(0);
    chk("t4_arvalid", arv_cycles, 0);

    ar_stall = 1'b1;
    start_xfer(64'h3000, 64'h40, 1024, 4);
    finish_xfer(16);
    ar_stall = 1'b0;
    chk("t5_err", err, 1);
    chk("t5_err_lat", err_cyc - bad_cyc, 1);

    start_xfer(64'h8000, 64'h0, 2048, -1);
    n = 0;
    while (t_cnt < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("t6_progress", t_cnt >= 10, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_done", done, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);
    chk("t6_arvalid", m_axi_arvalid, 0);
    chk("t6_araddr", m_axi_araddr, 0);
    chk("t6_arlen", m_axi_arlen, 0);
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_tdata", m_axis_tdata, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    rst_n = 1'b1;

    start_xfer(64'h9000, 64'h0, 1024, -1);
    repeat (2) @(negedge clk);
    req = 1'b1;
    xfer_bytes = 32'd64;
    addr_base = 64'h0;
    @(negedge clk);
    req = 1'b0;
    finish_xfer(16);
    repeat (20) @(negedge clk);
    chk("t7_one_done", done_cnt, 1);
    chk("t7_ar_cnt", ar_addr_q.size(), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_rd_stream_master.md
Name: axi_rd_stream_master

Overview:
- Read-side responder for the conv engine's buffer fetch handshake (req / addr_base / addr_offset / done).
- On a req pulse it fetches a contiguous region of global memory through AXI4 read bursts.
- It streams the returned 512-bit words, in order, out of an AXI-Stream master port into the IFM or WGT switch buffer.
- It pulses done once the last word has been accepted downstream.
- One instance serves IFM and one serves WGT.

Parameters:
- DATA_WIDTH, 512, AXI R / AXIS data width in bits; BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 64, AXI address width.
- BURST_LEN, 16, maximum beats per AXI burst (1..256).
- FIFO_DEPTH, 32, skid FIFO depth in beats. Must be >= BURST_LEN and a power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- req  in  1  one-cycle start pulse from the buffer controller.
- addr_base  in  ADDR_WIDTH  region base byte address.
- addr_offset  in  ADDR_WIDTH  byte offset added to addr_base.
- xfer_bytes  in  32  transfer length in bytes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from accepted req until the done pulse.
- err  out  1  sticky: a non-OKAY rresp was seen during the current transfer.
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_araddr  out  ADDR_WIDTH  burst start address.
- m_axi_arlen  out  8  beats-1.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- m_axi_rdata  in  DATA_WIDTH  R data.
- m_axi_rlast  in  1  R last.
- m_axi_rresp  in  2  R response.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tdata  out  DATA_WIDTH  stream data.

Behaviour:
- Reset values: done, busy, err, arvalid, tvalid = 0; araddr, arlen, tdata = 0. FIFO and all counters are cleared.
- Reset asserted mid-transfer abandons the transfer immediately. No done is produced. The next req after reset operates normally.
- Accepting a request:
  - req is accepted only when busy=0; req while busy=1 is ignored.
  - On accept, latch start = addr_base + addr_offset.
  - Latch total_beats = ceil(xfer_bytes / BYTES).
  - Clear err and set busy.
- Preconditions, not checked by the block: start is BYTES-aligned, and each burst of up to BURST_LEN*BYTES bytes does not cross a 4 KB boundary. No burst splitting is performed.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
  - IDLE: on accepted req, go to ISSUE, or go to FINISH if total_beats==0.
  - ISSUE: compute n = min(BURST_LEN, ar_remaining).
    - Drive arvalid=1 only when credit >= n, where credit = FIFO_DEPTH - fifo_count - outstanding_beats.
    - araddr = start + ar_issued_beats*BYTES; arlen = n-1.
    - araddr and arlen are held stable while arvalid=1 and arready=0.
    - On handshake: ar_issued_beats += n and outstanding_beats += n.
    - When ar_remaining reaches 0, go to WAIT. Multiple bursts may be outstanding.
  - WAIT: when out_beats == total_beats (the last AXIS handshake), go to FINISH.
  - FINISH: done=1 for exactly one cycle, busy drops with it, go to IDLE.
  - For total_beats==0, done pulses the cycle after req and no AR is issued.
- R channel:
  - rready = 1 whenever busy; credit accounting guarantees FIFO space.
  - Each R handshake writes rdata into the FIFO and decrements outstanding_beats.
  - rlast is not used for counting; beats are counted.
  - rresp != 0 on any beat sets err. Data is still forwarded.
- AXIS side:
  - tvalid = FIFO not empty; tdata = FIFO head (first-word fall-through). A beat pops on tvalid & tready.
  - Latency: an R beat handshaken in cycle t is presented on tvalid in cycle t+1 if the FIFO was empty.
  - tdata is stable while tvalid=1 and tready=0.
- Simultaneous FIFO push and pop in the same cycle leaves fifo_count unchanged.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. Beat counters are 32-bit and never wrap within one transfer.
- Partial words: the trailing bytes of the final word beyond xfer_bytes are forwarded unmodified.

Test Plan:
- Two full bursts: base=0x1000, offset=0x400, xfer_bytes=2048, arready=1, tready=1 -> two ARs, araddr 0x1400 then 0x1800, arlen=15 each. 32 AXIS beats in rdata order, done pulses once, the cycle after the 32nd handshake.
- Short transfer: xfer_bytes=100 -> single AR with arlen=1, exactly 2 AXIS beats, then done.
- Backpressure: xfer_bytes=4096 (64 beats), tready=0 for 200 cycles, then 1.
  - Arvalid never issues a burst exceeding free credit; at most 32 beats buffered.
  - All 64 beats are delivered in order with no loss and no duplication.
- Zero length: xfer_bytes=0 -> done pulses the cycle after req, arvalid never asserts.
- Error response: rresp=2'b10 on beat 5 of a 16-beat transfer -> err=1 from the next cycle, all 16 beats still forwarded, done still pulses. err clears on the next accepted req.
- Reset and ignored req: rst_n low after 10 of 32 beats -> all outputs 0, no done. Fresh req of 1024 bytes completes normally. A second req issued while busy is ignored, giving exactly one done pulse.
